// File: rtl/hazard_ctrl_if.sv
// Purpose: pipeline-side bundle between the datapath and the hazard sequencer.
// Latency: none, plain wires.
// Backpressure: none carried here; stalls are the payload of this bundle.
// Ports (slave = hazard_ctrl view):
//   in : start_i, id_rs1_i, id_rs2_i, ex_memread_i, ex_rd_i, branch_taken_i,
//        dmem_req_i, dmem_ack_i
//   out: pc_write_o, ifid_stall_o, ifid_flush_o, idex_bubble_o, mem_stall_o,
//        err_o, stall_cnt_o, flush_cnt_o
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             start_i;
  logic [4:0]       id_rs1_i;
  logic [4:0]       id_rs2_i;
  logic             ex_memread_i;
  logic [4:0]       ex_rd_i;
  logic             branch_taken_i;
  logic             dmem_req_i;
  logic             dmem_ack_i;
  logic             pc_write_o;
  logic             ifid_stall_o;
  logic             ifid_flush_o;
  logic             idex_bubble_o;
  logic             mem_stall_o;
  logic             err_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;

  // Pipeline / datapath side.
  modport master (
    output start_i, id_rs1_i, id_rs2_i, ex_memread_i, ex_rd_i,
           branch_taken_i, dmem_req_i, dmem_ack_i,
    input  pc_write_o, ifid_stall_o, ifid_flush_o, idex_bubble_o,
           mem_stall_o, err_o, stall_cnt_o, flush_cnt_o
  );

  // Hazard sequencer side.
  modport slave (
    input  start_i, id_rs1_i, id_rs2_i, ex_memread_i, ex_rd_i,
           branch_taken_i, dmem_req_i, dmem_ack_i,
    output pc_write_o, ifid_stall_o, ifid_flush_o, idex_bubble_o,
           mem_stall_o, err_o, stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Purpose: stall/flush sequencer for the 5-stage pipeline (load-use, branch flush, D$ miss freeze).
// Latency: all pipeline controls are combinational in the cycle of the event; counters/err update on the next edge.
// Backpressure: a data-cache miss freezes the whole pipeline via mem_stall_o until dmem_ack_i.
// Ports: clk_i clock, rst_i async active-low reset, hz (hazard_ctrl_if.slave) carrying
//   the ID/EX hazard inputs, branch and D$ handshake in, and the PC/IF_ID/ID_EX controls,
//   sticky timeout error and saturating stall/flush counters out.
module hazard_ctrl #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic         clk_i,
  input  logic         rst_i,
  hazard_ctrl_if.slave hz
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_RUN      = 2'd1;
  localparam logic [1:0] ST_MEM_WAIT = 2'd2;

  logic [1:0]        state_q;
  logic [1:0]        state_d;
  logic [WAIT_W-1:0] wait_cnt_q;
  logic              err_q;
  logic [CNT_W-1:0]  stall_cnt_q;
  logic [CNT_W-1:0]  flush_cnt_q;

  logic miss;
  logic waiting;
  logic freeze;
  logic active;
  logic load_use;
  logic stall_ev;
  logic flush_ev;

  assign miss    = hz.dmem_req_i & ~hz.dmem_ack_i;
  assign waiting = (state_q == ST_MEM_WAIT) & ~hz.dmem_ack_i;

  // The freeze is raised in the very cycle of the miss, before the FSM has
  // moved, so the MEM stage never advances past an unfinished access.
  assign freeze = ((state_q == ST_RUN) & miss) | waiting;

  // The ack cycle of MEM_WAIT is a normal running cycle: the pipeline
  // re-presents the hazard/branch inputs that were held during the freeze.
  assign active = ((state_q == ST_RUN) | (state_q == ST_MEM_WAIT)) & ~freeze;

  assign load_use = hz.ex_memread_i & (hz.ex_rd_i != 5'd0) &
                    ((hz.ex_rd_i == hz.id_rs1_i) | (hz.ex_rd_i == hz.id_rs2_i));

  // Load-use wins over a taken branch; the branch stays in ID and resolves
  // again next cycle, so dropping the flush here loses nothing.
  assign stall_ev = active & load_use;
  assign flush_ev = active & hz.branch_taken_i & ~load_use;

  assign hz.pc_write_o    = active & ~load_use;
  assign hz.ifid_stall_o  = ~active | load_use;
  assign hz.ifid_flush_o  = flush_ev;
  assign hz.idex_bubble_o = stall_ev;
  assign hz.mem_stall_o   = freeze;
  assign hz.err_o         = err_q;
  assign hz.stall_cnt_o   = stall_cnt_q;
  assign hz.flush_cnt_o   = flush_cnt_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (hz.start_i) state_d = ST_RUN;
      end
      ST_RUN: begin
        // An outstanding miss must be waited out even if start_i drops.
        if (miss)             state_d = ST_MEM_WAIT;
        else if (!hz.start_i) state_d = ST_IDLE;
      end
      ST_MEM_WAIT: begin
        if (hz.dmem_ack_i) state_d = hz.start_i ? ST_RUN : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= ST_IDLE;
      wait_cnt_q  <= '0;
      err_q       <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q <= state_d;

      // wait_cnt counts completed MEM_WAIT cycles without ack; it parks at
      // MEM_TIMEOUT so it cannot wrap during an arbitrarily long wait.
      if (waiting) begin
        if (wait_cnt_q != WAIT_MAX) wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
        if (wait_cnt_q == WAIT_LAST) err_q <= 1'b1;
      end else begin
        wait_cnt_q <= '0;
      end

      if (stall_ev && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush_ev && (flush_cnt_q != {CNT_W{1'b1}})) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Drives PC write-enable, IF_ID stall/flush, the ID_EX bubble and the global memory freeze.
- Detects load-use hazards in ID, applies branch-taken flushes and tracks data-cache miss waits with a small FSM.
- Keeps sticky error and performance counters for stalls and flushes.

Parameters:
- CNT_W, 16, width of the stall and flush performance counters
- MEM_TIMEOUT, 255, maximum number of MEM_WAIT cycles before err_o is set

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-low reset
- start_i  in  1  pipeline run enable; low holds the pipeline idle
- id_rs1_i  in  5  rs1 index of the instruction in ID
- id_rs2_i  in  5  rs2 index of the instruction in ID
- ex_memread_i  in  1  instruction in EX is a load
- ex_rd_i  in  5  rd index of the instruction in EX
- branch_taken_i  in  1  branch in ID resolved as taken
- dmem_req_i  in  1  MEM stage is issuing a data-cache access this cycle
- dmem_ack_i  in  1  data cache completes the access this cycle
- pc_write_o  out  1  PC register update enable
- ifid_stall_o  out  1  IF_ID hold
- ifid_flush_o  out  1  IF_ID clear to NOP
- idex_bubble_o  out  1  ID_EX control fields zeroed
- mem_stall_o  out  1  global freeze of all pipeline registers and the PC
- err_o  out  1  sticky flag: memory wait timeout
- stall_cnt_o  out  CNT_W  count of load-use stall cycles
- flush_cnt_o  out  CNT_W  count of branch flush cycles

Behaviour:
- Reset (rst_i=0, asynchronous):
  - state=IDLE, wait_cnt=0, err_o=0, both counters=0.
  - Combinational outputs follow the IDLE values below.
- States:
  - IDLE: pc_write_o=0, ifid_stall_o=1, all other controls 0. Moves to RUN on the clock edge after start_i=1 is sampled.
  - RUN: normal operation.
  - MEM_WAIT: data-cache miss outstanding.
- Transitions:
  - RUN -> MEM_WAIT when dmem_req_i=1 and dmem_ack_i=0.
  - MEM_WAIT -> RUN when dmem_ack_i=1.
  - start_i=0 in RUN -> IDLE.
  - start_i=0 in MEM_WAIT is ignored until the ack arrives; the FSM then goes to IDLE instead of RUN.
- mem_stall_o is combinational, so it is effective in the same cycle as the miss:
  - asserted in RUN when dmem_req_i=1 and dmem_ack_i=0;
  - asserted in MEM_WAIT when dmem_ack_i=0;
  - deasserted in the ack cycle.
- While mem_stall_o=1:
  - pc_write_o=0, ifid_stall_o=1, ifid_flush_o=0, idex_bubble_o=0.
  - Hazard and branch inputs are ignored.
  - The frozen pipeline re-presents those inputs after the freeze, so they are applied then.
- Load-use hazard (RUN, no freeze):
  - Condition: ex_memread_i=1, ex_rd_i!=0, and ex_rd_i equals id_rs1_i or id_rs2_i.
  - Response: pc_write_o=0, ifid_stall_o=1, idex_bubble_o=1.
  - Exactly one bubble per load.
- Branch taken (RUN, no freeze, no load-use): ifid_flush_o=1, pc_write_o=1.
- Load-use and branch in the same cycle: the load-use response wins and ifid_flush_o=0; the branch resolves again next cycle.
- No event in RUN: pc_write_o=1, all other controls 0.
- Timeout:
  - wait_cnt increments each MEM_WAIT cycle and clears on leaving MEM_WAIT.
  - When wait_cnt reaches MEM_TIMEOUT, err_o is set and stays set until reset.
  - The FSM keeps waiting after err_o is set.
- Counters:
  - stall_cnt_o increments on each load-use stall cycle.
  - flush_cnt_o increments on each flush cycle.
  - Both saturate at all-ones and do not wrap.
- Reset mid MEM_WAIT: immediate return to IDLE; a pending miss is abandoned.

Test Plan:
- Reset, then start_i=1 -> cycle 0 shows pc_write_o=0 and ifid_stall_o=1; from cycle 1, RUN with pc_write_o=1.
- ex_memread_i=1, ex_rd_i=5, id_rs2_i=5 -> one cycle of pc_write_o=0, ifid_stall_o=1, idex_bubble_o=1; stall_cnt_o=1. Repeat with ex_rd_i=0 -> no stall.
- branch_taken_i=1 for one cycle -> ifid_flush_o=1 and pc_write_o=1 in that cycle; flush_cnt_o=1.
- Same cycle as the previous two: load-use with branch_taken_i=1 -> stall only, ifid_flush_o=0.
- dmem_req_i=1 with ack after 4 cycles -> mem_stall_o=1 for exactly 4 cycles, 0 in the ack cycle. A branch_taken_i held during the freeze flushes only after release.
- MEM_TIMEOUT=8, no ack for 10 cycles -> err_o rises after the 8th wait cycle. Late ack -> RUN, err_o stays 1. Assert rst_i=0 mid-wait -> IDLE and err_o=0 asynchronously.
